// File: rtl/branch_predict_unit.sv
// Branch resolver plus direct-mapped BTB with 2-bit counters.
// Fetch reads the table combinationally; execute trains it on the clock.
module branch_predict_unit #(
   parameter int          IDX_W      = 6,
   parameter int          TAG_W      = 8,
   parameter bit          PREDICT_EN = 1'b1,
   parameter logic [1:0]  CNT_INIT   = 2'b10
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] f_pc_i,
   output logic        f_pred_taken_o,
   output logic [31:0] f_pred_target_o,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_instr_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_target_i,
   input  logic        ex_br_equal_i,
   input  logic        ex_br_less_i,
   input  logic        ex_pred_taken_i,
   input  logic [31:0] ex_pred_target_i,
   output logic        is_taken_o,
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] br_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int N   = 1 << IDX_W;
   localparam int TLO = IDX_W + 2;
   localparam int THI = IDX_W + TAG_W + 1;

   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic [N-1:0]     valid_q;
   logic [TAG_W-1:0] tag_q    [N];
   logic [31:0]      target_q [N];
   logic [1:0]       ctr_q    [N];

   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   logic             r_hit;
   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_b;
   logic       is_j;
   logic       b_cond;
   logic       taken;
   logic       train;

   assign r_idx = f_pc_i[IDX_W+1:2];
   assign r_tag = f_pc_i[THI:TLO];
   assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

   assign f_pred_taken_o  = PREDICT_EN && r_hit && ctr_q[r_idx][1];
   assign f_pred_target_o = f_pred_taken_o ? target_q[r_idx] : 32'd0;

   assign opcode = ex_instr_i[6:0];
   assign funct3 = ex_instr_i[14:12];

   always_comb begin
      is_b = 1'b0;
      is_j = 1'b0;
      unique case (1'b1)
         (opcode == OP_B):    is_b = 1'b1;
         (opcode == OP_JAL):  is_j = 1'b1;
         (opcode == OP_JALR): is_j = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      b_cond = 1'b0;
      unique case (funct3)
         3'b000:         b_cond = ex_br_equal_i;
         3'b001:         b_cond = !ex_br_equal_i;
         3'b100, 3'b110: b_cond = ex_br_less_i;
         3'b101, 3'b111: b_cond = !ex_br_less_i;
         default:        b_cond = 1'b0;
      endcase
   end

   assign taken = is_j || (is_b && b_cond);

   assign is_taken_o    = ex_valid_i && taken;
   assign mispredict_o  = ex_valid_i &&
                          ((taken != ex_pred_taken_i) ||
                           (taken && (ex_target_i != ex_pred_target_i)));
   assign redirect_pc_o = !ex_valid_i ? 32'd0 :
                          taken ? ex_target_i : ex_pc_i + 32'd4;

   assign w_idx = ex_pc_i[IDX_W+1:2];
   assign w_tag = ex_pc_i[THI:TLO];
   assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
   assign train = ex_valid_i && PREDICT_EN;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < N; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CNT_INIT;
         end
      end else if (train) begin
         unique case (1'b1)
            is_b: begin
               if (w_hit) begin
                  if (taken) begin
                     target_q[w_idx] <= ex_target_i;
                     if (ctr_q[w_idx] != 2'b11)
                        ctr_q[w_idx] <= ctr_q[w_idx] + 2'd1;
                  end else if (ctr_q[w_idx] != 2'b00) begin
                     ctr_q[w_idx] <= ctr_q[w_idx] - 2'd1;
                  end
               end else if (taken) begin
                  valid_q[w_idx]  <= 1'b1;
                  tag_q[w_idx]    <= w_tag;
                  target_q[w_idx] <= ex_target_i;
                  ctr_q[w_idx]    <= CNT_INIT;
               end
            end
            is_j: begin
               valid_q[w_idx]  <= 1'b1;
               tag_q[w_idx]    <= w_tag;
               target_q[w_idx] <= ex_target_i;
               ctr_q[w_idx]    <= 2'b11;
            end
            default: begin
               // a non-control op matching an entry means the entry is stale
               if (w_hit) valid_q[w_idx] <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_cnt_o   <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (ex_valid_i && (is_b || is_j) && (br_cnt_o != '1))
            br_cnt_o <= br_cnt_o + 32'd1;
         if (mispredict_o && (miss_cnt_o != '1))
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{f_pc_i[31:THI+1], f_pc_i[1:0],
                          ex_pc_i[31:THI+1], ex_pc_i[1:0],
                          ex_instr_i[31:15], ex_instr_i[11:7]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Vector-table bench for branch_predict_unit with a queued scoreboard.
// A second instance with prediction disabled runs on the same stimulus.
module tb_branch_predict_unit;

   localparam logic [31:0] BEQ  = 32'h0000_0063;
   localparam logic [31:0] BNE  = 32'h0000_1063;
   localparam logic [31:0] B010 = 32'h0000_2063;
   localparam logic [31:0] BLT  = 32'h0000_4063;
   localparam logic [31:0] BGE  = 32'h0000_5063;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;
   localparam logic [31:0] ADDI = 32'h0000_0013;

   typedef struct {
      logic [31:0] f_pc;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        eq;
      logic        lt;
      logic        pt;
      logic [31:0] ptgt;
      logic        ctl;
      logic        e_fpt;
      logic [31:0] e_fptgt;
      logic        e_tk;
      logic        e_mp;
      logic [31:0] e_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] f_pc;
   logic        f_pt, np_f_pt;
   logic [31:0] f_ptgt, np_f_ptgt;
   logic        ex_v;
   logic [31:0] ex_instr, ex_pc, ex_tgt, ex_ptgt;
   logic        ex_eq, ex_lt, ex_pt;
   logic        tk, np_tk;
   logic        mp, np_mp;
   logic [31:0] rd, np_rd;
   logic [31:0] br_cnt, np_br_cnt;
   logic [31:0] miss_cnt, np_miss_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_br = 0;
   int exp_miss = 0;

   vec_t vt[$];
   vec_t sb[$];
   vec_t e;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .IDX_W(6), .TAG_W(8), .PREDICT_EN(1'b1), .CNT_INIT(2'b10)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .f_pc_i(f_pc),
      .f_pred_taken_o(f_pt), .f_pred_target_o(f_ptgt),
      .ex_valid_i(ex_v), .ex_instr_i(ex_instr), .ex_pc_i(ex_pc),
      .ex_target_i(ex_tgt), .ex_br_equal_i(ex_eq),
      .ex_br_less_i(ex_lt), .ex_pred_taken_i(ex_pt),
      .ex_pred_target_i(ex_ptgt), .is_taken_o(tk),
      .mispredict_o(mp), .redirect_pc_o(rd),
      .br_cnt_o(br_cnt), .miss_cnt_o(miss_cnt)
   );

   branch_predict_unit #(
      .IDX_W(6), .TAG_W(8), .PREDICT_EN(1'b0), .CNT_INIT(2'b10)
   ) u_np (
      .clk_i(clk), .rst_ni(rst_n), .f_pc_i(f_pc),
      .f_pred_taken_o(np_f_pt), .f_pred_target_o(np_f_ptgt),
      .ex_valid_i(ex_v), .ex_instr_i(ex_instr), .ex_pc_i(ex_pc),
      .ex_target_i(ex_tgt), .ex_br_equal_i(ex_eq),
      .ex_br_less_i(ex_lt), .ex_pred_taken_i(ex_pt),
      .ex_pred_target_i(ex_ptgt), .is_taken_o(np_tk),
      .mispredict_o(np_mp), .redirect_pc_o(np_rd),
      .br_cnt_o(np_br_cnt), .miss_cnt_o(np_miss_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [31:0] f_pc_a, input logic v_a,
      input logic [31:0] instr_a, input logic [31:0] pc_a,
      input logic [31:0] tgt_a, input logic eq_a, input logic lt_a,
      input logic pt_a, input logic [31:0] ptgt_a, input logic ctl_a,
      input logic fpt_a, input logic [31:0] fptgt_a,
      input logic tk_a, input logic mp_a, input logic [31:0] rd_a);
      vec_t r;
      r.f_pc = f_pc_a;   r.v = v_a;       r.instr = instr_a;
      r.pc = pc_a;       r.tgt = tgt_a;   r.eq = eq_a;
      r.lt = lt_a;       r.pt = pt_a;     r.ptgt = ptgt_a;
      r.ctl = ctl_a;     r.e_fpt = fpt_a; r.e_fptgt = fptgt_a;
      r.e_tk = tk_a;     r.e_mp = mp_a;   r.e_rd = rd_a;
      return r;
   endfunction

   task automatic drive(input vec_t d);
      f_pc = d.f_pc;   ex_v = d.v;     ex_instr = d.instr;
      ex_pc = d.pc;    ex_tgt = d.tgt; ex_eq = d.eq;
      ex_lt = d.lt;    ex_pt = d.pt;   ex_ptgt = d.ptgt;
   endtask

   task automatic idle(input logic [31:0] pc_a);
      drive(mk(pc_a, 0, ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      // f_pc, v, instr, pc, tgt, eq, lt, pt, ptgt, ctl,
      // exp f_pt, f_ptgt, taken, mispredict, redirect
      vt.push_back(mk(32'h100, 0, BEQ,  32'h100, 32'h140, 1, 0, 0, 0,
                      0, 0, 0, 0, 0, 0));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 1, 0, 0, 0,
                      1, 0, 0, 1, 1, 32'h140));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 0, 0, 1, 32'h140,
                      1, 1, 32'h140, 0, 1, 32'h104));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 32'h104));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 32'h104));
      vt.push_back(mk(32'h100, 0, BEQ,  32'h100, 32'h140, 1, 0, 0, 0,
                      0, 0, 0, 0, 0, 0));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 1, 0, 0, 0,
                      1, 0, 0, 1, 1, 32'h140));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h140, 1, 0, 0, 0,
                      1, 0, 0, 1, 1, 32'h140));
      vt.push_back(mk(32'h100, 1, BEQ,  32'h100, 32'h180, 1, 0, 1, 32'h140,
                      1, 1, 32'h140, 1, 1, 32'h180));
      vt.push_back(mk(32'h100, 0, ADDI, 0, 0, 0, 0, 0, 0,
                      0, 1, 32'h180, 0, 0, 0));
      vt.push_back(mk(32'h100, 1, B010, 32'h100, 32'h180, 1, 1, 1, 32'h180,
                      1, 1, 32'h180, 0, 1, 32'h104));
      vt.push_back(mk(32'h100, 1, ADDI, 32'h200, 0, 0, 0, 0, 0,
                      0, 1, 32'h180, 0, 0, 32'h204));
      vt.push_back(mk(32'h100, 1, ADDI, 32'h100, 0, 0, 0, 1, 32'h180,
                      0, 1, 32'h180, 0, 1, 32'h104));
      vt.push_back(mk(32'h100, 0, ADDI, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0));
      vt.push_back(mk(32'hFFFF_FFFC, 1, JALR, 32'hFFFF_FFFC, 32'h200,
                      0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h200));
      vt.push_back(mk(32'hFFFF_FFFC, 1, BNE, 32'hFFFF_FFFC, 32'h300,
                      1, 0, 1, 32'h200, 1, 1, 32'h200, 0, 1, 32'h0));
      vt.push_back(mk(32'hFFFF_FFFC, 0, ADDI, 0, 0, 0, 0, 0, 0,
                      0, 1, 32'h200, 0, 0, 0));
      vt.push_back(mk(32'h300, 1, BLT,  32'h300, 32'h380, 0, 1, 0, 0,
                      1, 0, 0, 1, 1, 32'h380));
      vt.push_back(mk(32'h300, 1, JAL,  32'h400, 32'h480, 0, 0, 1, 32'h480,
                      1, 1, 32'h380, 1, 0, 32'h480));
      vt.push_back(mk(32'h300, 0, ADDI, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0));
      vt.push_back(mk(32'h400, 1, BGE,  32'h400, 32'h480, 0, 0, 1, 32'h480,
                      1, 1, 32'h480, 1, 0, 32'h480));
      vt.push_back(mk(32'h400, 0, BEQ,  32'h400, 32'h999, 1, 1, 0, 0,
                      1, 1, 32'h480, 0, 0, 0));

      rst_n = 1'b0;
      idle(32'h100);
      #1;
      chk("rst_f_pt", {31'd0, f_pt}, 0);
      chk("rst_f_ptgt", f_ptgt, 0);
      chk("rst_br_cnt", br_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         drive(vt[i]);
         sb.push_back(vt[i]);
         #2;
         if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_f_pt", i), {31'd0, f_pt}, {31'd0, e.e_fpt});
            chk($sformatf("v%0d_f_ptgt", i), f_ptgt, e.e_fptgt);
            chk($sformatf("v%0d_taken", i), {31'd0, tk}, {31'd0, e.e_tk});
            chk($sformatf("v%0d_mispred", i), {31'd0, mp}, {31'd0, e.e_mp});
            chk($sformatf("v%0d_redirect", i), rd, e.e_rd);
            chk($sformatf("v%0d_br_cnt", i), br_cnt, exp_br);
            chk($sformatf("v%0d_miss_cnt", i), miss_cnt, exp_miss);
            chk($sformatf("v%0d_np_f_pt", i), {31'd0, np_f_pt}, 0);
            chk($sformatf("v%0d_np_f_ptgt", i), np_f_ptgt, 0);
            chk($sformatf("v%0d_np_redirect", i), np_rd, e.e_rd);
            if (e.v && e.ctl) exp_br++;
            if (e.e_mp) exp_miss++;
         end
      end

      @(negedge clk);
      idle(32'h400);
      #2;
      chk("pre_rst_br_cnt", br_cnt, exp_br);
      chk("pre_rst_f_pt", {31'd0, f_pt}, 1);

      // reset lands in the middle of a cycle carrying a pending JAL
      @(negedge clk);
      drive(mk(32'h400, 1, JAL, 32'h500, 32'h600, 0, 0, 0, 0,
               1, 0, 0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_br_cnt", br_cnt, 0);
      chk("mid_rst_miss_cnt", miss_cnt, 0);
      chk("mid_rst_f_pt", {31'd0, f_pt}, 0);
      chk("mid_rst_f_ptgt", f_ptgt, 0);
      @(negedge clk);
      idle(32'h500);
      rst_n = 1'b1;
      #2;
      chk("post_rst_jal_dropped", {31'd0, f_pt}, 0);
      f_pc = 32'h100;
      #1;
      chk("post_rst_f_pt_100", {31'd0, f_pt}, 0);
      chk("post_rst_br_cnt", br_cnt, 0);
      chk("np_br_cnt", np_br_cnt, 0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1);
   end

endmodule
